decode_unit: RTL and testbench
==============================

DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/PC width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2); AW = log2(NREG).
REQ-003 SHALL have parameter NFWD, default 3, number of forwarding sources (index 0 highest priority).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports f_ir  input  32  and f_pc  input  WIDTH  fetched instruction and its PC.
REQ-007 SHALL have port flush  input  1  kill the instruction entering D.
REQ-008 SHALL have ports fwd_valid  input  NFWD, fwd_ready  input  NFWD, fwd_addr  input  NFWD*AW, and fwd_data  input  NFWD*WIDTH  later-stage write-backs.
REQ-009 SHALL have ports w_we  input  1, w_addr  input  AW, and w_data  input  WIDTH  register-file write port.
REQ-010 SHALL have ports ir_d  output  32, pc_d  output  WIDTH, rs_data  output  WIDTH, and rt_data  output  WIDTH  decoded operands.
REQ-011 SHALL have ports br_taken  output  1  and stall  output  1.

Function
REQ-012 SHALL hold IR/PC in a D register loaded from f_ir/f_pc each cycle when stall=0; SHALL hold the value when stall=1.
REQ-013 SHALL load ir_d=0 (nop) and pc_d unchanged when flush=1 and stall=0; if stall=1, stall wins and flush SHALL be ignored.
REQ-014 SHALL read rs=ir_d[25:21] and rt=ir_d[20:16] with AW-bit truncation; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-015 For each operand, the lowest index i with fwd_valid[i]=1, fwd_addr[i]=operand address, and address≠0 SHALL be selected; if fwd_ready[i]=1, the operand SHALL be fwd_data[i]; otherwise stall SHALL be 1.
REQ-016 With no forwarding match, the operand SHALL come from the register file.
REQ-017 stall SHALL be combinational; a stalled instruction SHALL re-evaluate each cycle until fwd_ready rises, with no cycle limit.
REQ-018 The branch comparator SHALL decode ir_d for beq, bne, bgez, bltz, bgtz, blez, and bgezalr; all other opcodes SHALL give br_taken=0.
REQ-019 Comparisons SHALL be signed WIDTH-bit on forwarded operands.
REQ-020 br_taken SHALL be forced to 0 while stall=1.
REQ-021 Register write SHALL occur at the clock edge; a simultaneous read of w_addr in the same cycle SHALL return the old value unless the configuration feature is enabled.
REQ-022 Latency SHALL be: f_ir to ir_d 1 cycle; operands and br_taken combinational from ir_d.

Reset
REQ-023 On reset=0 at an edge: ir_d=0, pc_d=0, all registers=0; rs_data=rt_data=0, br_taken=0, stall=0 the cycle after.
REQ-024 Reset SHALL override stall and flush; reset during a stall SHALL drop the stalled instruction.

Configuration
REQ-025 SHALL support macro DECODE_WRITE_THROUGH_EN: when defined, a read of an address equal to w_addr with w_we=1 and address≠0 SHALL return w_data in the same cycle, at lower priority than fwd sources; when undefined, it SHALL return the stored value (W forwarding is then supplied via fwd ports).

Structure
REQ-026 Opcode/funct constants and the branch-kind enumeration SHALL live in shared package cpu_pkg.
REQ-027 The register file SHALL be sub-module grf_core (param WIDTH, NREG; 2 read ports, 1 write port).

Verification
REQ-028 Write r5=0x1234 via w port, next cycle ir_d reads rs=5 → rs_data=0x00001234.
REQ-029 fwd_valid[0]=fwd_valid[2]=1, both addr=7, data 0xAA/0xBB, ready=1 → rt_data=0xAA, stall=0.
REQ-030 fwd_valid[1]=1, addr=rs, ready=0 for 3 cycles → stall=1 for 3 cycles, ir_d held, br_taken=0; ready=1 → stall=0.
REQ-031 beq with rs=rt=0xFFFFFFFF → br_taken=1; bgez with rs=0x80000000 → 0; bgtz with rs=1 → 1.
REQ-032 flush=1 with stall=0 → ir_d=0; flush=1 with stall=1 → ir_d unchanged.
REQ-033 Write r3=9 and read r3 in the same cycle → 9 with DECODE_WRITE_THROUGH_EN, old value without; reset=0 mid-stall → ir_d=0, stall=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants and branch-kind decode for the decode stage.
package cpu_pkg;

  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_BGEZALR = 6'h3b;

  // REGIMM sub-opcodes carried in the rt field
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BGEZ,
    BR_BLTZ,
    BR_BGTZ,
    BR_BLEZ,
    BR_BGEZALR
  } br_kind_e;

  function automatic br_kind_e br_kind(input logic [31:0] ir);
    br_kind_e k;
    k = BR_NONE;
    case (ir[31:26])
      OP_BEQ:     k = BR_BEQ;
      OP_BNE:     k = BR_BNE;
      OP_BLEZ:    k = BR_BLEZ;
      OP_BGTZ:    k = BR_BGTZ;
      OP_BGEZALR: k = BR_BGEZALR;
      OP_REGIMM: begin
        if (ir[20:16] == RT_BLTZ)      k = BR_BLTZ;
        else if (ir[20:16] == RT_BGEZ) k = BR_BGEZ;
      end
      default:    k = BR_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/grf_core.sv
// General register file: two combinational read ports, one write port, r0 hardwired to zero.
// DECODE_WRITE_THROUGH_EN makes a same-cycle read of the written address return the new data.
module grf_core #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
`ifdef DECODE_WRITE_THROUGH_EN
    if (we && raddr_a != '0 && raddr_a == waddr) rdata_a = wdata;
    if (we && raddr_b != '0 && raddr_b == waddr) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage: D register, operand fetch with prioritised forwarding, stall and branch resolve.
// Write-through of the register-file write port is selected by DECODE_WRITE_THROUGH_EN (see grf_core).
module decode_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int NFWD  = 3,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           f_ir,
  input  logic [WIDTH-1:0]      f_pc,
  input  logic                  flush,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD-1:0]       fwd_ready,
  input  logic [NFWD*AW-1:0]    fwd_addr,
  input  logic [NFWD*WIDTH-1:0] fwd_data,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic [WIDTH-1:0]      w_data,
  output logic [31:0]           ir_d,
  output logic [WIDTH-1:0]      pc_d,
  output logic [WIDTH-1:0]      rs_data,
  output logic [WIDTH-1:0]      rt_data,
  output logic                  br_taken,
  output logic                  stall
);

  logic [AW-1:0]    rs_a, rt_a;
  logic [WIDTH-1:0] rf_rs, rf_rt, fwd_rs, fwd_rt;
  logic             hit_rs, hit_rt, rdy_rs, rdy_rt, cond;

  assign rs_a = AW'(ir_d[25:21]);
  assign rt_a = AW'(ir_d[20:16]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_d <= '0;
      pc_d <= '0;
    end else if (!stall) begin
      if (flush) begin
        ir_d <= '0;
      end else begin
        ir_d <= f_ir;
        pc_d <= f_pc;
      end
    end
  end

  grf_core #(.WIDTH(WIDTH), .NREG(NREG)) u_grf (
    .clk     (clk),
    .reset   (reset),
    .we      (w_we),
    .waddr   (w_addr),
    .wdata   (w_data),
    .raddr_a (rs_a),
    .raddr_b (rt_a),
    .rdata_a (rf_rs),
    .rdata_b (rf_rt)
  );

  // Scan from the lowest-priority source upward so the lowest index overwrites.
  always_comb begin
    hit_rs = 1'b0; rdy_rs = 1'b0; fwd_rs = '0;
    hit_rt = 1'b0; rdy_rt = 1'b0; fwd_rt = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && rs_a != '0 && fwd_addr[i*AW +: AW] == rs_a) begin
        hit_rs = 1'b1;
        rdy_rs = fwd_ready[i];
        fwd_rs = fwd_data[i*WIDTH +: WIDTH];
      end
      if (fwd_valid[i] && rt_a != '0 && fwd_addr[i*AW +: AW] == rt_a) begin
        hit_rt = 1'b1;
        rdy_rt = fwd_ready[i];
        fwd_rt = fwd_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rs_data = hit_rs ? fwd_rs : rf_rs;
  assign rt_data = hit_rt ? fwd_rt : rf_rt;
  assign stall   = (hit_rs && !rdy_rs) || (hit_rt && !rdy_rt);

  always_comb begin
    cond = 1'b0;
    case (br_kind(ir_d))
      BR_BEQ:     cond = (rs_data == rt_data);
      BR_BNE:     cond = (rs_data != rt_data);
      BR_BGEZ,
      BR_BGEZALR: cond = !rs_data[WIDTH-1];
      BR_BLTZ:    cond = rs_data[WIDTH-1];
      BR_BGTZ:    cond = !rs_data[WIDTH-1] && (rs_data != '0);
      BR_BLEZ:    cond = rs_data[WIDTH-1] || (rs_data == '0);
      default:    cond = 1'b0;
    endcase
  end

  assign br_taken = cond && !stall;

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: a reference model predicts each cycle, a monitor compares on negedge.
// Expectations follow DECODE_WRITE_THROUGH_EN when the bundle is built with it.
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_ir, f_pc;
  logic        flush;
  logic [2:0]  fwd_valid, fwd_ready;
  logic [4:0]  fa [3];
  logic [31:0] fd [3];
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] ir_d, pc_d, rs_data, rt_data;
  logic        br_taken, stall;

  assign fwd_addr = {fa[2], fa[1], fa[0]};
  assign fwd_data = {fd[2], fd[1], fd[0]};

  always #5 clk = ~clk;

  decode_unit #(.WIDTH(32), .NREG(32), .NFWD(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .f_ir      (f_ir),
    .f_pc      (f_pc),
    .flush     (flush),
    .fwd_valid (fwd_valid),
    .fwd_ready (fwd_ready),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .ir_d      (ir_d),
    .pc_d      (pc_d),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .br_taken  (br_taken),
    .stall     (stall)
  );

  typedef struct {
    logic [31:0] ir, pc, rs, rt;
    bit          br, st;
  } exp_t;

  exp_t        sb_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_ir, m_pc;
  bit          model_ok = 1'b0;

`ifdef DECODE_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h0};
  endfunction

  // Operand value as the architecture defines it: lowest matching forwarder, else register file.
  function automatic void operand(input logic [4:0] a, output logic [31:0] v, output bit st);
    bit found;
    v = 32'h0; st = 1'b0; found = 1'b0;
    if (a != 5'd0) begin
      for (int i = 0; i < 3; i++) begin
        if (!found && fwd_valid[i] && fa[i] == a) begin
          found = 1'b1;
          if (fwd_ready[i]) v = fd[i];
          else st = 1'b1;
        end
      end
      if (!found) v = (WT && w_we && w_addr == a) ? w_data : m_regs[a];
    end
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit s1, s2, t;
    int signed a, b;
    operand(m_ir[25:21], e.rs, s1);
    operand(m_ir[20:16], e.rt, s2);
    e.st = s1 | s2;
    e.ir = m_ir;
    e.pc = m_pc;
    a = $signed(e.rs);
    b = $signed(e.rt);
    case (m_ir[31:26])
      6'h04:   t = (a == b);
      6'h05:   t = (a != b);
      6'h06:   t = (a <= 0);
      6'h07:   t = (a > 0);
      6'h3b:   t = (a >= 0);
      6'h01:   t = (m_ir[20:16] == 5'd0) ? (a < 0) : (m_ir[20:16] == 5'd1) ? (a >= 0) : 1'b0;
      default: t = 1'b0;
    endcase
    e.br = t && !e.st;
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    e = predict();
    if (model_ok) sb_q.push_back(e);
    @(posedge clk);
    if (!reset) begin
      m_ir = 32'h0;
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (w_we && w_addr != 5'd0) m_regs[w_addr] = w_data;
      if (!e.st) begin
        if (flush) m_ir = 32'h0;
        else begin
          m_ir = f_ir;
          m_pc = f_pc;
        end
      end
    end
    #1;
  endtask

  task automatic quiet();
    reset = 1'b1; flush = 1'b0; w_we = 1'b0; w_addr = 5'd0; w_data = 32'h0;
    fwd_valid = 3'b000; fwd_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      fa[i] = 5'd0;
      fd[i] = 32'h0;
    end
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("ir_d", ir_d, e.ir);
      chk("pc_d", pc_d, e.pc);
      chk("stall", {31'h0, stall}, {31'h0, e.st});
      chk("br_taken", {31'h0, br_taken}, {31'h0, e.br});
      if (!e.st) begin
        chk("rs_data", rs_data, e.rs);
        chk("rt_data", rt_data, e.rt);
      end
    end
  end

  initial begin
    quiet();
    f_ir = 32'h0; f_pc = 32'h0;
    m_ir = 32'h0; m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    reset = 1'b0;
    cycle();
    // reset state; write r5 and fetch an instruction reading rs=5
    quiet();
    f_ir = mk(6'h00, 5'd5, 5'd0); f_pc = 32'h100;
    w_we = 1'b1; w_addr = 5'd5; w_data = 32'h1234;
    cycle();
    f_ir = mk(6'h00, 5'd0, 5'd7); f_pc = 32'h104;
    w_addr = 5'd1; w_data = 32'hFFFF_FFFF;
    cycle();
    // two forwarders on r7: index 0 must win
    f_ir = mk(6'h00, 5'd9, 5'd0); f_pc = 32'h108;
    w_addr = 5'd2;
    fwd_valid = 3'b101; fwd_ready = 3'b111;
    fa[0] = 5'd7; fd[0] = 32'hAA; fa[2] = 5'd7; fd[2] = 32'hBB;
    cycle();
    // r9 pending on source 1 for three cycles
    quiet();
    fwd_valid = 3'b010; fa[1] = 5'd9; fd[1] = 32'h55;
    for (int k = 0; k < 3; k++) begin
      f_ir = $urandom; f_pc = 32'h200 + 32'(k);
      cycle();
    end
    fwd_ready = 3'b010;
    f_ir = mk(6'h04, 5'd1, 5'd2); f_pc = 32'h10c;
    cycle();
    quiet();
    fwd_valid = 3'b001; fwd_ready = 3'b001; fa[0] = 5'd4; fd[0] = 32'h8000_0000;
    f_ir = {6'h01, 5'd4, 5'd1, 16'h0}; f_pc = 32'h110;
    cycle();
    fa[0] = 5'd6; fd[0] = 32'h1;
    f_ir = mk(6'h07, 5'd6, 5'd0); f_pc = 32'h114;
    cycle();
    fa[0] = 5'd4; fd[0] = 32'h8000_0000;
    f_ir = mk(6'h00, 5'd9, 5'd0); f_pc = 32'h118;
    cycle();
    // flush without stall, then load an r9 reader and flush while stalled
    quiet();
    flush = 1'b1; f_ir = 32'hDEAD_BEEF; f_pc = 32'h11c;
    cycle();
    flush = 1'b0; f_ir = mk(6'h00, 5'd9, 5'd0); f_pc = 32'h120;
    cycle();
    fwd_valid = 3'b010; fa[1] = 5'd9; flush = 1'b1; f_ir = 32'h1111_1111;
    cycle();
    cycle();
    // write r3=5, load reader, then write r3=9 while reading it
    quiet();
    w_we = 1'b1; w_addr = 5'd3; w_data = 32'd5;
    f_ir = mk(6'h00, 5'd3, 5'd3); f_pc = 32'h124;
    cycle();
    w_data = 32'd9; f_ir = mk(6'h00, 5'd9, 5'd0); f_pc = 32'h128;
    cycle();
    // reset while stalled on r9
    quiet();
    fwd_valid = 3'b001; fa[0] = 5'd9;
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] ops [8];
      ops = '{6'h00, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h3b, 6'h00};
      ops[7] = 6'($urandom);
      f_ir = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      f_pc = $urandom;
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 49) != 0);
      fwd_valid = 3'($urandom);
      fwd_ready = 3'($urandom) | 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        fa[i] = 5'($urandom_range(0, 7));
        fd[i] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      end
      w_we = $urandom_range(0, 1);
      w_addr = 5'($urandom_range(0, 7));
      w_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle();
    end
    quiet();
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
